// File: rtl/stream_sink_addr_gen.sv
// Stream sink address generator: turns valid/status stream tokens into sequential BRAM writes.
// Define STREAM_SINK_WRAP_EN for circular-buffer mode (no FULL state, done pulses on each wrap).
module stream_sink_addr_gen #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              rstx,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              status,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ACTIVE = 1'b0,
        FULL   = 1'b1
    } state_t;

    state_t              state_reg,   state_next;
    logic [ADDR_W-1:0]   ptr_reg,     ptr_next;
    logic [ADDR_W:0]     count_reg,   count_next;
    logic                wr_en_reg,   wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
    logic                status_reg,  status_next;
    logic                done_reg,    done_next;
    logic                accept;

    // status is a register, so acceptance never loops combinationally through valid.
    assign accept = valid & status_reg & ~clear;

    always_ff @(posedge clk) begin
        if (rstx) begin
            state_reg   <= ACTIVE;
            ptr_reg     <= '0;
            count_reg   <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            status_reg  <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            count_reg   <= count_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            status_reg  <= status_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        count_next   = count_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
`ifdef STREAM_SINK_WRAP_EN
        done_next    = 1'b0;
`endif

        if (clear) begin
            state_next = ACTIVE;
            ptr_next   = '0;
            count_next = '0;
        end else if (accept) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ptr_reg;
            wr_data_next = data_in;
`ifdef STREAM_SINK_WRAP_EN
            count_next = (count_reg == FULL_COUNT) ? count_reg : count_reg + 1'b1;
            if (ptr_reg == LAST_PTR) begin
                ptr_next  = '0;
                done_next = 1'b1;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
`else
            count_next = count_reg + 1'b1;
            // The last slot closes the gate on the same edge, so nothing lands past DEPTH.
            if (ptr_reg == LAST_PTR) begin
                state_next = FULL;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
`endif
        end

        status_next = (state_next == ACTIVE);
`ifndef STREAM_SINK_WRAP_EN
        done_next   = (state_next == FULL);
`endif
    end

    assign status  = status_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign count   = count_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_stream_sink_addr_gen.sv
// Self-checking bench for stream_sink_addr_gen: directed test-plan sequences plus random traffic
// against a token-counting reference model (DEPTH=4, DATA_W=8).
module tb_stream_sink_addr_gen;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef STREAM_SINK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstx = 1'b0;
    logic              clear = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              status;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   count;
    logic              done;

    stream_sink_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstx(rstx), .clear(clear), .valid(valid), .data_in(data_in),
        .status(status), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: tokens accepted since reset/clear, plus the last write seen.
    int          m_total   = 0;
    bit          m_wr_en   = 0;
    int          m_addr    = 0;
    int          m_data    = 0;
    bit          m_pulse   = 0;

    function automatic bit m_full();
        return !WRAP && (m_total >= DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input logic [DATA_W-1:0] d);
        bit acc;
        rstx = r; clear = c; valid = v; data_in = d;
        acc = !r && !c && v && !m_full();
        @(posedge clk);
        #1;
        cycle++;
        m_pulse = 0;
        if (r) begin
            m_total = 0; m_wr_en = 0; m_addr = 0; m_data = 0;
        end else if (c) begin
            m_total = 0; m_wr_en = 0;
        end else if (acc) begin
            m_wr_en = 1;
            m_addr  = m_total % DEPTH;
            m_data  = int'(d);
            m_total++;
            m_pulse = WRAP && (m_total % DEPTH == 0);
        end else begin
            m_wr_en = 0;
        end
        rstx = 0; clear = 0; valid = 0;
        check("status",  32'(status),  32'(!m_full()));
        check("done",    32'(done),    32'(WRAP ? m_pulse : m_full()));
        check("wr_en",   32'(wr_en),   32'(m_wr_en));
        check("count",   32'(count),   32'((m_total > DEPTH) ? DEPTH : m_total));
        if (m_wr_en || r) begin
            check("wr_addr", 32'(wr_addr), 32'(m_addr));
            check("wr_data", 32'(wr_data), 32'(m_data));
        end else begin
            check("wr_addr_hold", 32'(wr_addr), 32'(m_addr));
            check("wr_data_hold", 32'(wr_data), 32'(m_data));
        end
    endtask

    initial begin
        int pulses;
        // Reset, then four back-to-back tokens filling the buffer.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 8'hA0 + 8'(i));
            check("plan_fill_addr", 32'(wr_addr), 32'(i));
        end
`ifndef STREAM_SINK_WRAP_EN
        check("plan_full_status", 32'(status), 32'd0);
        check("plan_full_done",   32'(done),   32'd1);
        check("plan_full_count",  32'(count),  32'd4);
        // Tokens presented while FULL are ignored.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'hFF);
            check("plan_full_noacc", 32'(wr_en), 32'd0);
        end
`endif
        // clear wins over a simultaneous token.
        step(0, 1, 1, 8'hEE);
        check("plan_clear_status", 32'(status), 32'd1);
        check("plan_clear_count",  32'(count),  32'd0);
        step(0, 0, 1, 8'h55);
        check("plan_clear_addr", 32'(wr_addr), 32'd0);
        check("plan_clear_data", 32'(wr_data), 32'h55);
        // Gapped input after a fresh clear.
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h11);
        step(0, 0, 0, 8'h00);
        check("plan_gap_hold", 32'(wr_addr), 32'd0);
        step(0, 0, 1, 8'h22);
        check("plan_gap_addr", 32'(wr_addr), 32'd1);
        step(0, 0, 0, 8'h00);
        // Reset mid-burst.
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h31);
        step(0, 0, 1, 8'h32);
        step(1, 0, 1, 8'h33);
        check("plan_rst_wren", 32'(wr_en), 32'd0);
        step(0, 0, 1, 8'h77);
        check("plan_rst_addr", 32'(wr_addr), 32'd0);
        // Six tokens from empty: wraps in circular mode, fills in fill-once mode.
        step(0, 1, 0, 8'h00);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 8'(8'h60 + i));
            if (done && WRAP) pulses++;
        end
`ifdef STREAM_SINK_WRAP_EN
        check("plan_wrap_pulses", 32'(pulses), 32'd1);
        check("plan_wrap_addr",   32'(wr_addr), 32'd1);
        check("plan_wrap_status", 32'(status),  32'd1);
`endif
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7, 8'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
